// File: rtl/disp_sched_amisha.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : disp_sched_amisha                                          |
// | Description : Front end for the 4-digit seven-segment display mux.      |
// |               Round-robin req/gnt arbitration between requesters A and  |
// |               B, per-digit pattern storage, hex to active-low segment   |
// |               decode, per-digit blinking and a registered output stage. |
// | Revision    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk_amisha            in   clock                                       |
// |   reset_amisha          in   asynchronous active-high reset              |
// |   clr_amisha            in   synchronous clear-all (wins over writes)    |
// |   a_req/dig/hex/dp/blk  in   requester A write request and fields        |
// |   a_gnt_amisha          out  requester A grant (combinational)           |
// |   b_req/dig/hex/dp/blk  in   requester B write request and fields        |
// |   b_gnt_amisha          out  requester B grant (combinational)           |
// |   in3..in0_amisha       out  8-bit patterns {~dp, g..a}, active-low      |
// |   upd_amisha            out  one-cycle pulse when in3..in0 refresh       |
// +--------------------------------------------------------------------------+
module disp_sched_amisha #(
  parameter int BLINK_N = 24
) (
  input  logic       clk_amisha,
  input  logic       reset_amisha,
  input  logic       clr_amisha,
  input  logic       a_req_amisha,
  input  logic [1:0] a_dig_amisha,
  input  logic [3:0] a_hex_amisha,
  input  logic       a_dp_amisha,
  input  logic       a_blk_amisha,
  output logic       a_gnt_amisha,
  input  logic       b_req_amisha,
  input  logic [1:0] b_dig_amisha,
  input  logic [3:0] b_hex_amisha,
  input  logic       b_dp_amisha,
  input  logic       b_blk_amisha,
  output logic       b_gnt_amisha,
  output logic [7:0] in3_amisha,
  output logic [7:0] in2_amisha,
  output logic [7:0] in1_amisha,
  output logic [7:0] in0_amisha,
  output logic       upd_amisha
);

  localparam logic [7:0]         c_BLANK   = 8'hFF;
  localparam logic [BLINK_N-1:0] c_CNT_ONE = {{(BLINK_N-1){1'b0}}, 1'b1};

  // Active-low segments {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] f_hex7(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // r_prio_b = 1 means B was not served last and wins a tie.
  logic                 r_prio_b;
  logic [7:0]           r_dig [4];
  logic [3:0]           r_blk;
  logic                 r_pend;
  logic [BLINK_N-1:0]   r_cnt;
  logic [7:0]           r_out [4];
  logic                 r_upd;

  logic                 w_a_gnt;
  logic                 w_b_gnt;
  logic                 w_wr;
  logic [1:0]           w_wr_dig;
  logic [7:0]           w_wr_pat;
  logic                 w_wr_blk;
  logic                 w_phase;

  // Grants are gated by reset and clr so a handshake in flight is dropped
  // the moment either one appears.
  always_comb begin
    w_a_gnt  = 1'b0;
    w_b_gnt  = 1'b0;
    w_wr_dig = a_dig_amisha;
    w_wr_pat = {~a_dp_amisha, f_hex7(a_hex_amisha)};
    w_wr_blk = a_blk_amisha;
    if (!reset_amisha && !clr_amisha) begin
      w_a_gnt = a_req_amisha & (~b_req_amisha | ~r_prio_b);
      w_b_gnt = b_req_amisha & (~a_req_amisha |  r_prio_b);
    end
    if (w_b_gnt) begin
      w_wr_dig = b_dig_amisha;
      w_wr_pat = {~b_dp_amisha, f_hex7(b_hex_amisha)};
      w_wr_blk = b_blk_amisha;
    end
    w_wr = w_a_gnt | w_b_gnt;
  end

  assign a_gnt_amisha = w_a_gnt;
  assign b_gnt_amisha = w_b_gnt;

  // Digit store, blink bits and RR pointer. r_pend marks that the store
  // changed at this edge so the output stage can flag the refresh.
  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      r_prio_b <= 1'b0;
      r_blk    <= 4'b0000;
      r_pend   <= 1'b0;
      for (int k = 0; k < 4; k++) r_dig[k] <= c_BLANK;
    end else if (clr_amisha) begin
      r_blk    <= 4'b0000;
      r_pend   <= 1'b1;
      for (int k = 0; k < 4; k++) r_dig[k] <= c_BLANK;
    end else begin
      r_pend <= w_wr;
      if (w_a_gnt) begin
        r_prio_b <= 1'b1;
      end else if (w_b_gnt) begin
        r_prio_b <= 1'b0;
      end
      if (w_wr) begin
        r_dig[w_wr_dig] <= w_wr_pat;
        r_blk[w_wr_dig] <= w_wr_blk;
      end
    end
  end

  // Free-running blink counter; wraps naturally at 2^BLINK_N.
  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_CNT_ONE;
    end
  end

  assign w_phase = r_cnt[BLINK_N-1];

  // Registered output stage: one cycle behind the digit store.
  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      r_upd <= 1'b0;
      for (int k = 0; k < 4; k++) r_out[k] <= c_BLANK;
    end else begin
      r_upd <= r_pend;
      for (int k = 0; k < 4; k++) begin
        r_out[k] <= (r_blk[k] & w_phase) ? c_BLANK : r_dig[k];
      end
    end
  end

  assign in0_amisha = r_out[0];
  assign in1_amisha = r_out[1];
  assign in2_amisha = r_out[2];
  assign in3_amisha = r_out[3];
  assign upd_amisha = r_upd;

endmodule
`default_nettype wire

// File: tb/tb_disp_sched_amisha.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_disp_sched_amisha                                       |
// | Description : Self-checking bench for disp_sched_amisha. Table of        |
// |               request vectors with expected grants; a digit model       |
// |               pushes expected display patterns into a scoreboard queue  |
// |               that is drained when the output stage should refresh.     |
// | Revision    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------------+
module tb_disp_sched_amisha;

  localparam int BLINK_N = 4;
  localparam int PERIOD  = 1 << BLINK_N;

  logic       clk_amisha = 1'b0;
  logic       reset_amisha;
  logic       clr_amisha;
  logic       a_req_amisha, a_dp_amisha, a_blk_amisha, a_gnt_amisha;
  logic [1:0] a_dig_amisha;
  logic [3:0] a_hex_amisha;
  logic       b_req_amisha, b_dp_amisha, b_blk_amisha, b_gnt_amisha;
  logic [1:0] b_dig_amisha;
  logic [3:0] b_hex_amisha;
  logic [7:0] in3_amisha, in2_amisha, in1_amisha, in0_amisha;
  logic       upd_amisha;

  always #5 clk_amisha = ~clk_amisha;

  disp_sched_amisha #(.BLINK_N(BLINK_N)) dut (
    .clk_amisha   (clk_amisha),
    .reset_amisha (reset_amisha),
    .clr_amisha   (clr_amisha),
    .a_req_amisha (a_req_amisha),
    .a_dig_amisha (a_dig_amisha),
    .a_hex_amisha (a_hex_amisha),
    .a_dp_amisha  (a_dp_amisha),
    .a_blk_amisha (a_blk_amisha),
    .a_gnt_amisha (a_gnt_amisha),
    .b_req_amisha (b_req_amisha),
    .b_dig_amisha (b_dig_amisha),
    .b_hex_amisha (b_hex_amisha),
    .b_dp_amisha  (b_dp_amisha),
    .b_blk_amisha (b_blk_amisha),
    .b_gnt_amisha (b_gnt_amisha),
    .in3_amisha   (in3_amisha),
    .in2_amisha   (in2_amisha),
    .in1_amisha   (in1_amisha),
    .in0_amisha   (in0_amisha),
    .upd_amisha   (upd_amisha)
  );

  typedef struct {
    logic       clr;
    logic       ar;  logic [1:0] ad; logic [3:0] ah; logic adp; logic ab;
    logic       br;  logic [1:0] bd; logic [3:0] bh; logic bdp; logic bb;
    logic       ea;  logic       eb;
  } vec_t;

  typedef struct {
    int               due;
    logic [3:0][7:0]  pat;
  } sb_t;

  vec_t       vq[$];
  sb_t        sb_q[$];
  logic [6:0] seg_tab [16];
  logic [7:0] m_dig [4];
  logic [3:0] m_blk;
  int         cyc;
  int         n_tests;
  int         n_fail;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add(input logic c,
                     input logic ar, input logic [1:0] ad, input logic [3:0] ah,
                     input logic adp, input logic ab,
                     input logic br, input logic [1:0] bd, input logic [3:0] bh,
                     input logic bdp, input logic bb,
                     input logic ea, input logic eb);
    vec_t v;
    v.clr = c;
    v.ar = ar; v.ad = ad; v.ah = ah; v.adp = adp; v.ab = ab;
    v.br = br; v.bd = bd; v.bh = bh; v.bdp = bdp; v.bb = bb;
    v.ea = ea; v.eb = eb;
    vq.push_back(v);
  endtask

  task automatic idle_inputs();
    clr_amisha   = 1'b0;
    a_req_amisha = 1'b0; a_dig_amisha = 2'd0; a_hex_amisha = 4'd0;
    a_dp_amisha  = 1'b0; a_blk_amisha = 1'b0;
    b_req_amisha = 1'b0; b_dig_amisha = 2'd0; b_hex_amisha = 4'd0;
    b_dp_amisha  = 1'b0; b_blk_amisha = 1'b0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_dig[k] = 8'hFF;
    m_blk = 4'b0000;
    sb_q.delete();
    cyc = 0;
  endtask

  // Called shortly after an active edge with inputs already driven.
  // Checks grants, advances the model across the next edge, then checks
  // upd and (when an entry is due) the four patterns.
  task automatic tick(input logic ea, input logic eb);
    sb_t        e;
    logic [7:0] outs [4];
    #1;
    chk("a_gnt", {7'd0, a_gnt_amisha}, {7'd0, ea});
    chk("b_gnt", {7'd0, b_gnt_amisha}, {7'd0, eb});
    if (clr_amisha) begin
      for (int k = 0; k < 4; k++) m_dig[k] = 8'hFF;
      m_blk = 4'b0000;
    end else if (ea) begin
      m_dig[a_dig_amisha] = {~a_dp_amisha, seg_tab[a_hex_amisha]};
      m_blk[a_dig_amisha] = a_blk_amisha;
    end else if (eb) begin
      m_dig[b_dig_amisha] = {~b_dp_amisha, seg_tab[b_hex_amisha]};
      m_blk[b_dig_amisha] = b_blk_amisha;
    end
    if (clr_amisha || ea || eb) begin
      e.due = cyc + 2;
      for (int k = 0; k < 4; k++) begin
        e.pat[k] = (m_blk[k] && (((cyc + 1) % PERIOD) >= PERIOD / 2)) ? 8'hFF : m_dig[k];
      end
      sb_q.push_back(e);
    end
    @(posedge clk_amisha);
    cyc++;
    #1;
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      e = sb_q.pop_front();
      outs = '{in0_amisha, in1_amisha, in2_amisha, in3_amisha};
      chk("upd", {7'd0, upd_amisha}, 8'd1);
      for (int k = 0; k < 4; k++) chk($sformatf("in%0d", k), outs[k], e.pat[k]);
    end else begin
      chk("upd", {7'd0, upd_amisha}, 8'd0);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Vector table: inputs and hand-derived grants.
    //   clr  A: req dig hex dp blk   B: req dig hex dp blk   exp a, b
    add(0, 1, 0, 4'h5, 1, 0,  0, 0, 4'h0, 0, 0,  1, 0); // single A write
    add(0, 0, 0, 4'h0, 0, 0,  0, 0, 4'h0, 0, 0,  0, 0);
    add(0, 1, 1, 4'h1, 0, 0,  1, 2, 4'h2, 1, 0,  0, 1); // both: B (A served last)
    add(0, 1, 1, 4'h3, 0, 0,  1, 2, 4'h4, 1, 0,  1, 0);
    add(0, 1, 1, 4'h6, 1, 0,  1, 2, 4'h7, 0, 0,  0, 1);
    add(0, 1, 1, 4'h8, 0, 0,  1, 2, 4'h9, 0, 0,  1, 0);
    add(0, 0, 0, 4'h0, 0, 0,  1, 0, 4'hA, 0, 0,  0, 1); // B only
    add(0, 1, 1, 4'hB, 1, 0,  1, 2, 4'hC, 1, 0,  1, 0); // then both: A
    add(0, 0, 0, 4'h0, 0, 0,  0, 0, 4'h0, 0, 0,  0, 0);
    add(1, 1, 1, 4'hD, 0, 0,  0, 0, 4'h0, 0, 0,  0, 0); // clr beats A
    add(0, 1, 1, 4'h9, 0, 0,  0, 0, 4'h0, 0, 0,  1, 0); // A next cycle
    add(1, 1, 0, 4'h1, 0, 0,  1, 3, 4'h2, 0, 0,  0, 0); // clr keeps pointer
    add(0, 1, 0, 4'h1, 0, 0,  1, 3, 4'h2, 0, 0,  0, 1); // B still favoured
    add(0, 0, 0, 4'h0, 0, 0,  0, 0, 4'h0, 0, 0,  0, 0);
    add(0, 0, 0, 4'h0, 0, 0,  0, 0, 4'h0, 0, 0,  0, 0);
    for (int h = 0; h < 16; h++) begin
      logic [3:0] hx;
      hx = 4'(h);
      add(0, 1, 3, hx, hx[0], 0,  0, 0, 4'h0, 0, 0,  1, 0); // hex sweep dig3
    end
    add(0, 0, 0, 4'h0, 0, 0,  0, 0, 4'h0, 0, 0,  0, 0);
    add(0, 0, 0, 4'h0, 0, 0,  0, 0, 4'h0, 0, 0,  0, 0);

    // Reset state, with both requests high to show grants are held off.
    idle_inputs();
    reset_amisha = 1'b1;
    a_req_amisha = 1'b1;
    b_req_amisha = 1'b1;
    @(posedge clk_amisha);
    @(posedge clk_amisha);
    #1;
    chk("rst_a_gnt", {7'd0, a_gnt_amisha}, 8'd0);
    chk("rst_b_gnt", {7'd0, b_gnt_amisha}, 8'd0);
    chk("rst_upd",   {7'd0, upd_amisha},   8'd0);
    chk("rst_in0", in0_amisha, 8'hFF);
    chk("rst_in1", in1_amisha, 8'hFF);
    chk("rst_in2", in2_amisha, 8'hFF);
    chk("rst_in3", in3_amisha, 8'hFF);
    idle_inputs();
    reset_amisha = 1'b0;
    model_reset();

    foreach (vq[i]) begin
      clr_amisha   = vq[i].clr;
      a_req_amisha = vq[i].ar; a_dig_amisha = vq[i].ad; a_hex_amisha = vq[i].ah;
      a_dp_amisha  = vq[i].adp; a_blk_amisha = vq[i].ab;
      b_req_amisha = vq[i].br; b_dig_amisha = vq[i].bd; b_hex_amisha = vq[i].bh;
      b_dp_amisha  = vq[i].bdp; b_blk_amisha = vq[i].bb;
      tick(vq[i].ea, vq[i].eb);
    end

    // Blinking digit: B writes F with dp lit and blink on to digit 2.
    idle_inputs();
    b_req_amisha = 1'b1; b_dig_amisha = 2'd2; b_hex_amisha = 4'hF;
    b_dp_amisha  = 1'b1; b_blk_amisha = 1'b1;
    tick(1'b0, 1'b1);
    idle_inputs();
    tick(1'b0, 1'b0);
    for (int i = 0; i < 2 * PERIOD + 4; i++) begin
      tick(1'b0, 1'b0);
      chk("in2_blink", in2_amisha, (((cyc - 1) % PERIOD) >= PERIOD / 2) ? 8'hFF : 8'h0E);
    end
    // Rewriting with blink off leaves the digit steady.
    a_req_amisha = 1'b1; a_dig_amisha = 2'd2; a_hex_amisha = 4'hF;
    a_dp_amisha  = 1'b1; a_blk_amisha = 1'b0;
    tick(1'b1, 1'b0);
    idle_inputs();
    tick(1'b0, 1'b0);
    for (int i = 0; i < PERIOD; i++) begin
      tick(1'b0, 1'b0);
      chk("in2_steady", in2_amisha, 8'h0E);
    end

    // Reset during a pending handshake. A was served last, so B would win.
    a_req_amisha = 1'b1; a_dig_amisha = 2'd3; a_hex_amisha = 4'h7;
    b_req_amisha = 1'b1; b_dig_amisha = 2'd1; b_hex_amisha = 4'h8;
    #2;
    reset_amisha = 1'b1;
    #1;
    chk("mid_rst_a_gnt", {7'd0, a_gnt_amisha}, 8'd0);
    chk("mid_rst_b_gnt", {7'd0, b_gnt_amisha}, 8'd0);
    chk("mid_rst_in2", in2_amisha, 8'hFF);
    @(posedge clk_amisha);
    #1;
    chk("mid_rst_in3", in3_amisha, 8'hFF);
    chk("mid_rst_in1", in1_amisha, 8'hFF);
    idle_inputs();
    reset_amisha = 1'b0;
    model_reset();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("no_commit_in3", in3_amisha, 8'hFF);
    chk("no_commit_in1", in1_amisha, 8'hFF);
    a_req_amisha = 1'b1; a_dig_amisha = 2'd0; a_hex_amisha = 4'hC;
    b_req_amisha = 1'b1; b_dig_amisha = 2'd1; b_hex_amisha = 4'hD;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    idle_inputs();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);

    chk("sb_drained", 8'(sb_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
